// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions used by the ID/EX pipeline stage.
//   - ALU function encodings (bits [5:4] pick the add/sub, logic, shift or
//     compare group in the ALU)
//   - register-0 index constant (register 0 is hardwired to zero)
//   - EX control bundle and a forwarding-match helper
package id_ex_stage_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [5:0] {
        ALU_ADD   = 6'b000000,
        ALU_SUB   = 6'b000001,
        ALU_AND   = 6'b011000,
        ALU_OR    = 6'b011110,
        ALU_XOR   = 6'b010110,
        ALU_NOR   = 6'b010001,
        ALU_PASSA = 6'b011010,
        ALU_SLL   = 6'b100000,
        ALU_SRL   = 6'b100001,
        ALU_SRA   = 6'b100011,
        ALU_EQ    = 6'b110011,
        ALU_NE    = 6'b110001,
        ALU_LT    = 6'b110101,
        ALU_LEZ   = 6'b111101,
        ALU_LTZ   = 6'b111011,
        ALU_GTZ   = 6'b111111
    } alu_fun_e;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ex_ctrl_t;

    // A later-stage write matches a source operand only for a nonzero index;
    // register 0 always reads as its stored (zero) value.
    function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] idx);
        return (rd == idx) && (idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/id_ex_stage_forward.sv
// Operand forwarding mux for one source operand.
// Ports:
//   idx          registered source register index
//   reg_data     register-file value captured in ID
//   exm_*        EX/MEM write-back candidate (highest priority)
//   mwb_*        MEM/WB write-back candidate
//   fwd_data     selected operand value
module forward_unit
    import id_ex_stage_pkg::*;
(
    input  logic [4:0]  idx,
    input  logic [31:0] reg_data,
    input  logic        exm_reg_write,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        mwb_reg_write,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_data,
    output logic [31:0] fwd_data
);

    always_comb begin
        fwd_data = reg_data;
        if (exm_reg_write && reg_hit(exm_rd, idx))
            fwd_data = exm_result;
        else if (mwb_reg_write && reg_hit(mwb_rd, idx))
            fwd_data = mwb_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection
// and bubble insertion.
// Ports:
//   clk, reset (async, active-low)
//   ID_*       decoded instruction fields from the ID stage
//   EXM_*/MWB_* forwarding sources from EX/MEM and MEM/WB
//   Flush      taken branch/jump: kill the instruction entering EX
//   DataA/DataB/ALUFun/Sign  ALU operands and function
//   EX_*       control and store data carried into EX/MEM
//   Stall      load-use hazard, hold PC and IF/ID
//   BubbleCount saturating count of inserted bubbles
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_Valid,
    input  logic [31:0] ID_RsData,
    input  logic [31:0] ID_RtData,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic [4:0]  ID_Rd,
    input  logic [31:0] ID_Imm,
    input  logic [4:0]  ID_Shamt,
    input  logic [5:0]  ID_ALUFun,
    input  logic        ID_Sign,
    input  logic        ID_ALUSrcA,
    input  logic        ID_ALUSrcB,
    input  logic        ID_RegWrite,
    input  logic        ID_MemRead,
    input  logic        ID_MemWrite,
    input  logic        EXM_RegWrite,
    input  logic [4:0]  EXM_Rd,
    input  logic [31:0] EXM_Result,
    input  logic        MWB_RegWrite,
    input  logic [4:0]  MWB_Rd,
    input  logic [31:0] MWB_Data,
    input  logic        Flush,
    output logic [31:0] DataA,
    output logic [31:0] DataB,
    output logic [5:0]  ALUFun,
    output logic        Sign,
    output logic        EX_Valid,
    output logic [4:0]  EX_Rd,
    output logic        EX_RegWrite,
    output logic        EX_MemRead,
    output logic        EX_MemWrite,
    output logic [31:0] EX_StoreData,
    output logic        Stall,
    output logic [15:0] BubbleCount
);

    ex_ctrl_t    ctrl_q;
    logic [4:0]  rs_q, rt_q, rd_q, shamt_q;
    logic [31:0] rs_data_q, rt_data_q, imm_q;
    logic [5:0]  alu_fun_q;
    logic        sign_q, src_a_q, src_b_q;
    logic [15:0] bubble_cnt_q;
    logic [31:0] fwd_a, fwd_b;
    logic        bubble;

    // Load-use hazard: the load in EX cannot supply its data in time.
    assign Stall = ctrl_q.valid && ctrl_q.mem_read && (rd_q != REG_ZERO) && ID_Valid
                   && ((rd_q == ID_Rs) || (rd_q == ID_Rt));

    // Stall and Flush together still produce only one bubble.
    assign bubble = Stall || Flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            shamt_q   <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            alu_fun_q <= '0;
            sign_q    <= 1'b0;
            src_a_q   <= 1'b0;
            src_b_q   <= 1'b0;
        end else if (bubble) begin
            // Data fields of a bubble are don't-care; only control is killed.
            ctrl_q    <= '0;
            alu_fun_q <= ALU_ADD;
        end else begin
            ctrl_q.valid     <= ID_Valid;
            ctrl_q.reg_write <= ID_Valid && ID_RegWrite;
            ctrl_q.mem_read  <= ID_Valid && ID_MemRead;
            ctrl_q.mem_write <= ID_Valid && ID_MemWrite;
            rs_q      <= ID_Rs;
            rt_q      <= ID_Rt;
            rd_q      <= ID_Rd;
            shamt_q   <= ID_Shamt;
            rs_data_q <= ID_RsData;
            rt_data_q <= ID_RtData;
            imm_q     <= ID_Imm;
            alu_fun_q <= ID_ALUFun;
            sign_q    <= ID_Sign;
            src_a_q   <= ID_ALUSrcA;
            src_b_q   <= ID_ALUSrcB;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bubble_cnt_q <= '0;
        else if (bubble && (bubble_cnt_q != 16'hFFFF))
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end

    forward_unit u_fwd_a (
        .idx           (rs_q),
        .reg_data      (rs_data_q),
        .exm_reg_write (EXM_RegWrite),
        .exm_rd        (EXM_Rd),
        .exm_result    (EXM_Result),
        .mwb_reg_write (MWB_RegWrite),
        .mwb_rd        (MWB_Rd),
        .mwb_data      (MWB_Data),
        .fwd_data      (fwd_a)
    );

    forward_unit u_fwd_b (
        .idx           (rt_q),
        .reg_data      (rt_data_q),
        .exm_reg_write (EXM_RegWrite),
        .exm_rd        (EXM_Rd),
        .exm_result    (EXM_Result),
        .mwb_reg_write (MWB_RegWrite),
        .mwb_rd        (MWB_Rd),
        .mwb_data      (MWB_Data),
        .fwd_data      (fwd_b)
    );

    assign DataA        = src_a_q ? {27'b0, shamt_q} : fwd_a;
    assign DataB        = src_b_q ? imm_q : fwd_b;
    assign EX_StoreData = fwd_b;
    assign ALUFun       = alu_fun_q;
    assign Sign         = sign_q;
    assign EX_Valid     = ctrl_q.valid;
    assign EX_Rd        = rd_q;
    assign EX_RegWrite  = ctrl_q.reg_write;
    assign EX_MemRead   = ctrl_q.mem_read;
    assign EX_MemWrite  = ctrl_q.mem_write;
    assign BubbleCount  = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ID-side inputs: ID_Valid 1, ID_RsData 32, ID_RtData 32, ID_Rs 5, ID_Rt 5, ID_Rd 5 (destination), ID_Imm 32 (already extended), ID_Shamt 5, ID_ALUFun 6, ID_Sign 1, ID_ALUSrcA 1 (1 = shamt), ID_ALUSrcB 1 (1 = imm), ID_RegWrite 1, ID_MemRead 1, ID_MemWrite 1.
REQ-004 SHALL have forwarding inputs: EXM_RegWrite 1, EXM_Rd 5, EXM_Result 32, MWB_RegWrite 1, MWB_Rd 5, MWB_Data 32.
REQ-005 SHALL have Flush  input  1  branch/jump taken, kill instruction entering EX.
REQ-006 SHALL have ALU-side outputs DataA 32, DataB 32, ALUFun 6, Sign 1.
REQ-007 SHALL have EX-side outputs EX_Valid 1, EX_Rd 5, EX_RegWrite 1, EX_MemRead 1, EX_MemWrite 1, EX_StoreData 32.
REQ-008 SHALL have Stall  output  1  hold PC and IF/ID this cycle; BubbleCount  output  16  inserted-bubble counter.

Function
REQ-009 SHALL capture all ID_* fields on each rising edge when neither Stall nor Flush is asserted; captured values appear in EX outputs one cycle later.
REQ-010 SHALL assert Stall combinationally when EX_Valid & EX_MemRead & EX_Rd != 0 & ID_Valid & (EX_Rd == ID_Rs | EX_Rd == ID_Rt) (load-use hazard).
REQ-011 SHALL, on Stall or Flush, load a bubble: EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite = 0, ALUFun = 0, all other captured fields don't-care.
REQ-012 SHALL treat Flush and Stall in the same cycle as one bubble; BubbleCount increments once.
REQ-013 SHALL increment BubbleCount by 1 per bubble inserted, saturating at 0xFFFF (no wrap).
REQ-014 SHALL compute forwarded A from registered Rs: EXM_Result if EXM_RegWrite & EXM_Rd == Rs & Rs != 0; else MWB_Data if MWB_RegWrite & MWB_Rd == Rs & Rs != 0; else registered RsData.
REQ-015 SHALL compute forwarded B identically from registered Rt (EX/MEM priority over MEM/WB, register 0 never forwarded).
REQ-016 SHALL drive DataA = ALUSrcA ? {27'b0, Shamt} : forwarded A; DataB = ALUSrcB ? Imm : forwarded B, combinationally from registered state and forwarding inputs (zero added latency).
REQ-017 SHALL drive EX_StoreData = forwarded B regardless of ALUSrcB.
REQ-018 SHALL pass ALUFun and Sign unchanged from captured values; ALUFun[5:4] selects add/sub, logic, shift, compare group downstream.
REQ-019 SHALL, when ID_Valid = 0 and no stall/flush, capture a bubble (EX_Valid = 0, all write/mem enables 0) without incrementing BubbleCount.

Reset
REQ-020 SHALL, while reset = 0, immediately clear EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, ALUFun, Sign, ALUSrcA, ALUSrcB, all data/index registers, and BubbleCount to 0.
REQ-021 SHALL hold Stall = 0 during reset (EX_Valid = 0); first capture occurs on first rising edge after reset deasserts.
REQ-022 SHALL make reset asserted mid-stall discard the in-flight bubble and counter state.

Structure
REQ-023 SHALL take ALUFun encodings (ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, PASSA 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NE 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111) and the register-0 index constant from the shared CPU package.
REQ-024 SHALL implement forwarding selection in one sub-module forward_unit, instantiated twice (A and B).

Verification
REQ-025 Forward EX/MEM: registered Rs=5, EXM_RegWrite=1, EXM_Rd=5, EXM_Result=0x1234, MWB_Rd=5, MWB_Data=0x9999 -> DataA=0x1234.
REQ-026 Register 0: Rt=0, EXM_RegWrite=1, EXM_Rd=0, EXM_Result=0xFFFFFFFF, RtData=0 -> DataB=0, EX_StoreData=0.
REQ-027 Load-use: EX holds lw to Rd=8, ID Rs=8 -> Stall=1 same cycle; next cycle EX_Valid=0, BubbleCount=1; following cycle instruction captured, Stall=0.
REQ-028 Flush+Stall together -> one bubble, BubbleCount +1, EX_MemWrite=0.
REQ-029 Saturation: preload 0xFFFE bubbles, insert 3 more -> BubbleCount=0xFFFF.
REQ-030 Reset mid-operation: EX_Valid=1, RegWrite=1, reset driven low between edges -> all outputs 0 before next edge; sll with ALUSrcA=1, Shamt=4, RtData=0x1 after reset -> DataA=0x4, DataB=0x1, ALUFun=100000.
